// File: rtl/gpu_executor.sv
// Consumer side of the CPU->GPU op FIFO: pops draw ops, rasterises clipped rectangles into the
// back framebuffer one pixel per enabled cycle, and parks on END_FRAME until the display swaps.
package gpu_pkg;
  typedef struct packed {
    logic        kind;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  w;
    logic [9:0]  h;
    logic [11:0] color;
  } gpu_op_t;

  localparam logic OpRect     = 1'b0;
  localparam logic OpEndFrame = 1'b1;
endpackage

module gpu_executor
  import gpu_pkg::*;
#(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  localparam int unsigned AW = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  gpu_op_t       op,
  output logic          op_rd_en,
  input  logic          op_empty,
  input  logic          swap,
  output logic          fb_wr_en,
  output logic [AW-1:0] fb_addr,
  output logic [11:0]   fb_data,
  output logic          fb_sel,
  output logic          status_busy,
  output logic          status_wait_swap
);

  // Row-base arithmetic is kept wide enough that y*HOR + x never wraps for any 10-bit y.
  localparam int unsigned BW = (AW + 1 > 20) ? AW + 1 : 20;

  typedef enum logic [1:0] {StIdle, StLatch, StDraw, StWaitSwap} state_e;

  state_e          state_q;
  logic [10:0]     cw_q, ch_q, col_q, row_q;
  logic [BW-1:0]   base_q;
  logic [11:0]     color_q;
  logic            fb_sel_q;

  logic [10:0]     x_ext, y_ext, w_ext, h_ext, room_x, room_y, cw, ch;
  logic [BW-1:0]   row_base;

  always_comb begin
    x_ext    = {1'b0, op.x};
    y_ext    = {1'b0, op.y};
    w_ext    = {1'b0, op.w};
    h_ext    = {1'b0, op.h};
    room_x   = 11'(HOR_ACTIVE_PIXELS) - x_ext;
    room_y   = 11'(VER_ACTIVE_PIXELS) - y_ext;
    cw       = '0;
    ch       = '0;
    if (x_ext < 11'(HOR_ACTIVE_PIXELS)) cw = (w_ext < room_x) ? w_ext : room_x;
    if (y_ext < 11'(VER_ACTIVE_PIXELS)) ch = (h_ext < room_y) ? h_ext : room_y;
    // One multiply per op at latch time; per-pixel addressing is purely incremental.
    row_base = BW'(op.y) * BW'(HOR_ACTIVE_PIXELS) + BW'(op.x);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cw_q     <= '0;
      ch_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      base_q   <= '0;
      color_q  <= '0;
      fb_sel_q <= 1'b0;
    end else if (ce) begin
      unique case (state_q)
        StIdle: begin
          if (!op_empty) state_q <= StLatch;
        end
        StLatch: begin
          if (op.kind == OpEndFrame) begin
            state_q <= StWaitSwap;
          end else if (cw == '0 || ch == '0) begin
            state_q <= StIdle;
          end else begin
            cw_q    <= cw;
            ch_q    <= ch;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= row_base;
            color_q <= op.color;
            state_q <= StDraw;
          end
        end
        StDraw: begin
          if (col_q == cw_q - 11'd1) begin
            col_q  <= '0;
            base_q <= base_q + BW'(HOR_ACTIVE_PIXELS);
            if (row_q == ch_q - 11'd1) state_q <= StIdle;
            else                       row_q   <= row_q + 11'd1;
          end else begin
            col_q <= col_q + 11'd1;
          end
        end
        StWaitSwap: begin
          if (swap) begin
            fb_sel_q <= ~fb_sel_q;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // rst gating keeps the pop strobe low while reset holds the FSM in IDLE.
  assign op_rd_en         = rst && ce && (state_q == StIdle) && !op_empty;
  assign fb_wr_en         = rst && ce && (state_q == StDraw);
  assign fb_addr          = AW'(base_q + BW'(col_q));
  assign fb_data          = color_q;
  assign fb_sel           = fb_sel_q;
  assign status_busy      = (state_q == StLatch) || (state_q == StDraw);
  assign status_wait_swap = (state_q == StWaitSwap);

endmodule

// File: tb/tb_gpu_executor.sv
// Directed bench for gpu_executor: a small FIFO model feeds ops, a negedge monitor logs pops and
// framebuffer writes, and the main sequence compares them against hand-computed values.
module tb_gpu_executor;
  import gpu_pkg::*;

  logic          clk;
  logic          rst;
  logic          ce;
  gpu_op_t       op;
  logic          op_rd_en;
  logic          op_empty;
  logic          swap;
  logic          fb_wr_en;
  logic [18:0]   fb_addr;
  logic [11:0]   fb_data;
  logic          fb_sel;
  logic          status_busy;
  logic          status_wait_swap;

  gpu_executor dut (
    .clk              (clk),
    .rst              (rst),
    .ce               (ce),
    .op               (op),
    .op_rd_en         (op_rd_en),
    .op_empty         (op_empty),
    .swap             (swap),
    .fb_wr_en         (fb_wr_en),
    .fb_addr          (fb_addr),
    .fb_data          (fb_data),
    .fb_sel           (fb_sel),
    .status_busy      (status_busy),
    .status_wait_swap (status_wait_swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after the pop strobe.
  gpu_op_t ops [64];
  int      wr_ptr = 0;
  int      rd_ptr = 0;
  assign op_empty = (rd_ptr == wr_ptr);

  initial op = '0;
  always @(posedge clk) begin
    if (op_rd_en) begin
      op     <= ops[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int   cyc_n   = 0;
  int   bad_pop = 0;
  int   wr_addr [$];
  int   wr_data [$];
  int   wr_cyc  [$];
  int   wr_ce   [$];
  int   pop_cyc [$];

  always @(negedge clk) begin
    if (fb_wr_en) begin
      wr_addr.push_back(int'(fb_addr));
      wr_data.push_back(int'(fb_data));
      wr_cyc.push_back(cyc_n);
      wr_ce.push_back(int'(ce));
    end
    if (op_rd_en) pop_cyc.push_back(cyc_n);
    if (op_rd_en && op_empty) bad_pop++;
    cyc_n++;
  end

  int vec = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_op(input logic kind, input int x, input int y, input int w, input int h,
                         input int color);
    gpu_op_t o;
    o.kind  = kind;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.w     = 10'(w);
    o.h     = 10'(h);
    o.color = 12'(color);
    ops[wr_ptr] = o;
    wr_ptr++;
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    wr_ce.delete();
    pop_cyc.delete();
  endtask

  function automatic int at(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int exp_a;
    rst  = 1'b0;
    ce   = 1'b1;
    swap = 1'b0;

    // Reset held with a RECT already queued.
    push_op(OpRect, 10, 5, 3, 2, 12'hF00);
    step(3);
    @(negedge clk);
    chk("rst_op_rd_en", op_rd_en, 0);
    chk("rst_fb_wr_en", fb_wr_en, 0);
    chk("rst_fb_sel", fb_sel, 0);
    chk("rst_busy", status_busy, 0);
    chk("rst_wait_swap", status_wait_swap, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_no_pop", pop_cyc.size(), 0);

    clear_logs();
    step(1);
    rst = 1'b1;
    @(negedge clk);
    chk("release_pop", op_rd_en, 1);
    step(12);
    chk("rect1_pops", pop_cyc.size(), 1);
    chk("rect1_nwr", wr_addr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      exp_a = 3210 + (i / 3) * 640 + (i % 3);
      chk($sformatf("rect1_addr%0d", i), at(wr_addr, i), exp_a);
      chk($sformatf("rect1_data%0d", i), at(wr_data, i), 12'hF00);
    end
    chk("rect1_latency", at(wr_cyc, 0) - at(pop_cyc, 0), 2);
    chk("rect1_contig", at(wr_cyc, 5) - at(wr_cyc, 0), 5);

    // Clipping: bottom-right corner, fully off-screen, then a 1x1.
    clear_logs();
    push_op(OpRect, 638, 479, 5, 3, 12'h0AB);
    push_op(OpRect, 700, 0, 4, 4, 12'h123);
    push_op(OpRect, 1, 0, 1, 1, 12'h456);
    step(16);
    chk("clip_nwr", wr_addr.size(), 3);
    chk("clip_addr0", at(wr_addr, 0), 307198);
    chk("clip_addr1", at(wr_addr, 1), 307199);
    chk("clip_addr2", at(wr_addr, 2), 1);
    chk("clip_data2", at(wr_data, 2), 12'h456);
    chk("clip_pops", pop_cyc.size(), 3);
    chk("clip_pop_after_wr", at(pop_cyc, 1) - at(wr_cyc, 1), 1);
    chk("clip_away_gap", at(pop_cyc, 2) - at(pop_cyc, 1), 2);

    // END_FRAME with a RECT queued behind it.
    clear_logs();
    push_op(OpEndFrame, 0, 0, 0, 0, 0);
    push_op(OpRect, 0, 1, 2, 1, 12'h0F0);
    step(10);
    chk("ef_pops", pop_cyc.size(), 1);
    chk("ef_wait_swap", status_wait_swap, 1);
    chk("ef_busy", status_busy, 0);
    chk("ef_fb_sel", fb_sel, 0);
    chk("ef_no_wr", wr_addr.size(), 0);
    swap = 1'b1;
    @(negedge clk);
    chk("swap_cycle_wait", status_wait_swap, 1);
    chk("swap_cycle_sel", fb_sel, 0);
    step(1);
    swap = 1'b0;
    @(negedge clk);
    chk("swap_sel_flip", fb_sel, 1);
    chk("swap_wait_fall", status_wait_swap, 0);
    chk("swap_pop_next", op_rd_en, 1);
    step(8);
    chk("ef_rect_nwr", wr_addr.size(), 2);
    chk("ef_rect_addr0", at(wr_addr, 0), 640);
    chk("ef_rect_addr1", at(wr_addr, 1), 641);
    push_op(OpEndFrame, 0, 0, 0, 0, 0);
    step(5);
    chk("ef2_wait_swap", status_wait_swap, 1);
    swap = 1'b1;
    step(1);
    swap = 1'b0;
    @(negedge clk);
    chk("ef2_sel_back", fb_sel, 0);

    // Clock enable toggling every cycle during a 4x4 RECT, with a stray swap mid-draw.
    step(1);
    clear_logs();
    push_op(OpRect, 20, 10, 4, 4, 12'hABC);
    for (int i = 0; i < 50; i++) begin
      step(1);
      ce   = (i % 2 == 0);
      swap = (i == 8);
    end
    step(1);
    ce   = 1'b1;
    swap = 1'b0;
    chk("ce_nwr", wr_addr.size(), 16);
    for (int k = 0; k < 16; k++) begin
      exp_a = 6420 + (k / 4) * 640 + (k % 4);
      chk($sformatf("ce_addr%0d", k), at(wr_addr, k), exp_a);
      chk($sformatf("ce_en%0d", k), at(wr_ce, k), 1);
    end
    chk("ce_data", at(wr_data, 15), 12'hABC);
    chk("draw_swap_ignored", fb_sel, 0);

    // Asynchronous reset between edges in the middle of a 8x2 RECT.
    clear_logs();
    push_op(OpRect, 0, 2, 8, 2, 12'h777);
    step(5);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_wr_en", fb_wr_en, 0);
    chk("arst_busy", status_busy, 0);
    chk("arst_addr", fb_addr, 0);
    chk("arst_data", fb_data, 0);
    step(3);
    rst = 1'b1;
    step(20);
    chk("arst_nwr", wr_addr.size(), 3);
    chk("arst_addr0", at(wr_addr, 0), 1280);
    chk("arst_addr2", at(wr_addr, 2), 1282);
    chk("arst_pops", pop_cyc.size(), 1);

    chk("no_pop_when_empty", bad_pop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
